// File: rtl/chacha_param_server.sv
// Key/nonce/counter store for the ChaCha20 controller.
// Serves one 32-bit word per request, with optional counter auto-increment.
module chacha_param_server #(
  parameter logic [31:0] CTR_RESET     = 32'h0000_0001,
  parameter logic [31:0] AUTO_INC_STEP = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr_en,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        cfg_err,
  input  logic        auto_inc_en,
  input  logic        core_busy,
  input  logic        core_done,
  input  logic        chunk_request,
  input  logic [1:0]  request_type,
  input  logic [4:0]  chunk_index,
  output logic        chunk_valid,
  output logic [1:0]  chunk_type,
  output logic [31:0] chunk,
  output logic        chunk_err,
  output logic [31:0] counter_value,
  output logic        ctr_wrap
);

  logic [31:0] r_key [0:7];
  logic [31:0] r_nonce [0:2];
  logic [31:0] r_ctr;
  logic        r_wrap;
  logic        r_valid;
  logic        r_err;
  logic        r_cfg_err;
  logic [1:0]  r_type;
  logic [31:0] r_chunk;

  logic        w_accept;
  logic        w_req_ok;
  logic [31:0] w_word;
  logic        w_cfg_ok;
  logic        w_key_wr;
  logic        w_nonce_wr;
  logic        w_ctr_wr;
  logic        w_inc;
  logic [32:0] w_sum;

  // A request seen while the pulse is out is the controller's repeat.
  assign w_accept = chunk_request & ~r_valid;

  always_comb begin
    w_req_ok = 1'b0;
    w_word   = '0;
    unique case (request_type)
      2'd0: begin
        w_req_ok = (chunk_index < 5'd8);
        w_word   = r_key[chunk_index[2:0]];
      end
      2'd1: begin
        w_req_ok = (chunk_index < 5'd3);
        case (chunk_index[1:0])
          2'd0:    w_word = r_nonce[0];
          2'd1:    w_word = r_nonce[1];
          2'd2:    w_word = r_nonce[2];
          default: w_word = '0;
        endcase
      end
      2'd2: begin
        w_req_ok = (chunk_index == 5'd0);
        w_word   = r_ctr;
      end
      default: begin
        w_req_ok = 1'b0;
        w_word   = '0;
      end
    endcase
  end

  assign w_cfg_ok   = cfg_wr_en & ~core_busy & (cfg_addr < 4'd12);
  assign w_key_wr   = w_cfg_ok & ~cfg_addr[3];
  assign w_nonce_wr = w_cfg_ok & cfg_addr[3] & (cfg_addr[1:0] != 2'd3);
  assign w_ctr_wr   = w_cfg_ok & (cfg_addr == 4'd11);
  assign w_inc      = core_done & auto_inc_en;
  assign w_sum      = {1'b0, r_ctr} + {1'b0, AUTO_INC_STEP};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_key[i] <= '0;
      for (int i = 0; i < 3; i++) r_nonce[i] <= '0;
      r_ctr     <= CTR_RESET;
      r_wrap    <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_cfg_err <= 1'b0;
      r_type    <= '0;
      r_chunk   <= '0;
    end else begin
      r_cfg_err <= cfg_wr_en & ~w_cfg_ok;
      if (w_key_wr) r_key[cfg_addr[2:0]] <= cfg_wdata;
      if (w_nonce_wr) begin
        case (cfg_addr[1:0])
          2'd0:    r_nonce[0] <= cfg_wdata;
          2'd1:    r_nonce[1] <= cfg_wdata;
          2'd2:    r_nonce[2] <= cfg_wdata;
          default: ;
        endcase
      end
      // Host counter write overrides a same-cycle increment.
      if (w_ctr_wr) begin
        r_ctr  <= cfg_wdata;
        r_wrap <= 1'b0;
      end else if (w_inc) begin
        r_ctr  <= w_sum[31:0];
        r_wrap <= r_wrap | w_sum[32];
      end
      r_valid <= w_accept & w_req_ok;
      r_err   <= w_accept & ~w_req_ok;
      if (w_accept & w_req_ok) begin
        r_type  <= request_type;
        r_chunk <= w_word;
      end
    end
  end

  // Pulses are masked while reset is held so a pending response never shows.
  assign chunk_valid   = r_valid & ~rst;
  assign chunk_err     = r_err & ~rst;
  assign chunk_type    = r_type;
  assign chunk         = r_chunk;
  assign cfg_err       = r_cfg_err;
  assign counter_value = r_ctr;
  assign ctr_wrap      = r_wrap;

endmodule

// File: tb/tb_chacha_param_server.sv
// Directed bench for chacha_param_server.
// Each task drives one scenario and checks outputs inline.
module tb_chacha_param_server;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr_en;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_err;
  logic        auto_inc_en;
  logic        core_busy;
  logic        core_done;
  logic        chunk_request;
  logic [1:0]  request_type;
  logic [4:0]  chunk_index;
  logic        chunk_valid;
  logic [1:0]  chunk_type;
  logic [31:0] chunk;
  logic        chunk_err;
  logic [31:0] counter_value;
  logic        ctr_wrap;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  chacha_param_server dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
    .auto_inc_en(auto_inc_en), .core_busy(core_busy),
    .core_done(core_done), .chunk_request(chunk_request),
    .request_type(request_type), .chunk_index(chunk_index),
    .chunk_valid(chunk_valid), .chunk_type(chunk_type),
    .chunk(chunk), .chunk_err(chunk_err),
    .counter_value(counter_value), .ctr_wrap(ctr_wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] key_word(int i);
    logic [7:0] b;
    b = 8'(4 * i);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    cfg_wr_en = 0; cfg_addr = 0; cfg_wdata = 0;
    auto_inc_en = 0; core_busy = 0; core_done = 0;
    chunk_request = 0; request_type = 0; chunk_index = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_total++;
    if (chunk_valid !== 1'b0 || chunk_err !== 1'b0 || cfg_err !== 1'b0)
      $display("FAIL reset_pulses v=%b e=%b c=%b expected 0 0 0",
               chunk_valid, chunk_err, cfg_err);
    else n_pass++;
    n_total++;
    if (counter_value !== 32'h1 || ctr_wrap !== 1'b0)
      $display("FAIL reset_ctr got %h/%b expected 00000001/0",
               counter_value, ctr_wrap);
    else n_pass++;
    n_total++;
    if (chunk !== 32'h0 || chunk_type !== 2'd0)
      $display("FAIL reset_chunk got %h/%0d expected 0/0",
               chunk, chunk_type);
    else n_pass++;
  endtask

  task automatic test_lock();
    core_busy = 1'b1;
    cfg_wr_en = 1'b1; cfg_addr = 4'd11; cfg_wdata = 32'd5;
    tick();
    cfg_wr_en = 1'b0;
    n_total++;
    if (cfg_err !== 1'b1 || counter_value !== 32'h1)
      $display("FAIL lock_write err=%b ctr=%h expected 1/00000001",
               cfg_err, counter_value);
    else n_pass++;
    tick();
    n_total++;
    if (cfg_err !== 1'b0)
      $display("FAIL lock_err_pulse got %b expected 0", cfg_err);
    else n_pass++;
    chunk_request = 1'b1; request_type = 2'd2; chunk_index = 0;
    tick();
    chunk_request = 1'b0;
    n_total++;
    if (chunk_valid !== 1'b1 || chunk !== 32'h1)
      $display("FAIL busy_read v=%b d=%h expected 1/00000001",
               chunk_valid, chunk);
    else n_pass++;
    core_busy = 1'b0;
    cfg_wr_en = 1'b1; cfg_addr = 4'd12; cfg_wdata = 32'h55;
    tick();
    cfg_wr_en = 1'b0;
    n_total++;
    if (cfg_err !== 1'b1)
      $display("FAIL bad_addr got %b expected 1", cfg_err);
    else n_pass++;
    tick();
  endtask

  task automatic write_cfg(input logic [3:0] a, input logic [31:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wr_en = 1'b0;
    n_total++;
    if (cfg_err !== 1'b0)
      $display("FAIL cfg_write a=%0d err got %b expected 0", a, cfg_err);
    else n_pass++;
  endtask

  task automatic test_hold_request();
    for (int i = 0; i < 8; i++) write_cfg(4'(i), key_word(i));
    chunk_request = 1'b1; request_type = 2'd0; chunk_index = 5'd5;
    tick();
    n_total++;
    if (chunk_valid !== 1'b1 || chunk !== 32'h14151617 || chunk_type !== 2'd0)
      $display("FAIL hold_first v=%b d=%h t=%0d expected 1/14151617/0",
               chunk_valid, chunk, chunk_type);
    else n_pass++;
    tick();
    chunk_request = 1'b0;
    n_total++;
    if (chunk_valid !== 1'b0 || chunk_err !== 1'b0)
      $display("FAIL hold_second v=%b e=%b expected 0/0",
               chunk_valid, chunk_err);
    else n_pass++;
    tick();
    n_total++;
    if (chunk_valid !== 1'b0 || chunk !== 32'h14151617)
      $display("FAIL hold_after v=%b d=%h expected 0/14151617",
               chunk_valid, chunk);
    else n_pass++;
  endtask

  task automatic test_sequence();
    logic [31:0] exp_w [12];
    logic [1:0]  exp_t [12];
    logic [4:0]  exp_i [12];
    int pulses;
    pulses = 0;
    for (int i = 0; i < 3; i++) write_cfg(4'(8 + i), 32'hA000_0000 + 32'(i));
    write_cfg(4'd11, 32'h1234_5678);
    for (int i = 0; i < 8; i++) begin
      exp_w[i] = key_word(i); exp_t[i] = 2'd0; exp_i[i] = 5'(i);
    end
    for (int i = 0; i < 3; i++) begin
      exp_w[8 + i] = 32'hA000_0000 + 32'(i);
      exp_t[8 + i] = 2'd1; exp_i[8 + i] = 5'(i);
    end
    exp_w[11] = 32'h1234_5678; exp_t[11] = 2'd2; exp_i[11] = 5'd0;
    for (int k = 0; k < 12; k++) begin
      chunk_request = 1'b1;
      request_type = exp_t[k]; chunk_index = exp_i[k];
      tick();
      if (chunk_valid === 1'b1) pulses++;
      n_total++;
      if (chunk_valid !== 1'b1 || chunk !== exp_w[k] || chunk_type !== exp_t[k])
        $display("FAIL seq_%0d v=%b d=%h t=%0d expected 1/%h/%0d",
                 k, chunk_valid, chunk, chunk_type, exp_w[k], exp_t[k]);
      else n_pass++;
      tick();
      if (chunk_valid === 1'b1) pulses++;
    end
    chunk_request = 1'b0;
    n_total++;
    if (pulses != 12)
      $display("FAIL seq_pulses got %0d expected 12", pulses);
    else n_pass++;
  endtask

  task automatic test_invalid();
    chunk_request = 1'b1; request_type = 2'd3; chunk_index = 0;
    tick();
    chunk_request = 1'b0;
    n_total++;
    if (chunk_err !== 1'b1 || chunk_valid !== 1'b0 || chunk !== 32'h1234_5678)
      $display("FAIL inv_type e=%b v=%b d=%h expected 1/0/12345678",
               chunk_err, chunk_valid, chunk);
    else n_pass++;
    tick();
    n_total++;
    if (chunk_err !== 1'b0)
      $display("FAIL inv_type_pulse got %b expected 0", chunk_err);
    else n_pass++;
    chunk_request = 1'b1; request_type = 2'd1; chunk_index = 5'd3;
    tick();
    chunk_request = 1'b0;
    n_total++;
    if (chunk_err !== 1'b1 || chunk_valid !== 1'b0 || chunk_type !== 2'd2)
      $display("FAIL inv_index e=%b v=%b t=%0d expected 1/0/2",
               chunk_err, chunk_valid, chunk_type);
    else n_pass++;
    tick();
    n_total++;
    if (chunk_err !== 1'b0 || chunk_valid !== 1'b0)
      $display("FAIL inv_index_after e=%b v=%b expected 0/0",
               chunk_err, chunk_valid);
    else n_pass++;
  endtask

  task automatic test_wrap();
    write_cfg(4'd11, 32'hFFFF_FFFF);
    auto_inc_en = 1'b1; core_done = 1'b1;
    tick();
    core_done = 1'b0;
    n_total++;
    if (counter_value !== 32'h0 || ctr_wrap !== 1'b1)
      $display("FAIL wrap got %h/%b expected 00000000/1",
               counter_value, ctr_wrap);
    else n_pass++;
    cfg_wr_en = 1'b1; cfg_addr = 4'd11; cfg_wdata = 32'd7;
    core_done = 1'b1;
    tick();
    cfg_wr_en = 1'b0; core_done = 1'b0;
    n_total++;
    if (counter_value !== 32'd7 || ctr_wrap !== 1'b0)
      $display("FAIL write_vs_done got %h/%b expected 00000007/0",
               counter_value, ctr_wrap);
    else n_pass++;
    core_done = 1'b1;
    tick();
    core_done = 1'b0; auto_inc_en = 1'b0;
    n_total++;
    if (counter_value !== 32'd8 || ctr_wrap !== 1'b0)
      $display("FAIL inc got %h/%b expected 00000008/0",
               counter_value, ctr_wrap);
    else n_pass++;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    n_total++;
    if (counter_value !== 32'd8)
      $display("FAIL inc_disabled got %h expected 00000008", counter_value);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    cfg_wr_en = 1'b1; cfg_addr = 4'd0; cfg_wdata = 32'hDEAD_BEEF;
    core_done = 1'b1; auto_inc_en = 1'b1;
    chunk_request = 1'b1; request_type = 2'd0; chunk_index = 0;
    tick();
    cfg_wr_en = 1'b0; core_done = 1'b0; auto_inc_en = 1'b0;
    n_total++;
    if (chunk_valid !== 1'b1 || chunk !== 32'h0001_0203 || counter_value !== 32'd9)
      $display("FAIL pre_write v=%b d=%h c=%h expected 1/00010203/00000009",
               chunk_valid, chunk, counter_value);
    else n_pass++;
    tick();
    tick();
    chunk_request = 1'b0;
    n_total++;
    if (chunk_valid !== 1'b1 || chunk !== 32'hDEAD_BEEF)
      $display("FAIL post_write v=%b d=%h expected 1/deadbeef",
               chunk_valid, chunk);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    write_cfg(4'd11, 32'hFFFF_FFFF);
    auto_inc_en = 1'b1; core_done = 1'b1;
    tick();
    core_done = 1'b0; auto_inc_en = 1'b0;
    chunk_request = 1'b1; request_type = 2'd0; chunk_index = 5'd5;
    tick();
    chunk_request = 1'b0;
    rst = 1'b1;
    #1;
    n_total++;
    if (chunk_valid !== 1'b0)
      $display("FAIL rst_mid_pulse got %b expected 0", chunk_valid);
    else n_pass++;
    tick();
    rst = 1'b0;
    n_total++;
    if (counter_value !== 32'h1 || ctr_wrap !== 1'b0 || chunk !== 32'h0
        || chunk_valid !== 1'b0)
      $display("FAIL rst_mid_regs c=%h w=%b d=%h v=%b expected 1/0/0/0",
               counter_value, ctr_wrap, chunk, chunk_valid);
    else n_pass++;
    chunk_request = 1'b1; request_type = 2'd0; chunk_index = 5'd5;
    tick();
    chunk_request = 1'b0;
    n_total++;
    if (chunk_valid !== 1'b1 || chunk !== 32'h0)
      $display("FAIL rst_mid_key v=%b d=%h expected 1/00000000",
               chunk_valid, chunk);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_hold_request();
    test_sequence();
    test_invalid();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/chacha_param_server.md
Name: chacha_param_server

Overview:
- Upstream neighbour of the ChaCha20 top-level controller.
- Holds host-programmed key (256 b), nonce (96 b) and block counter (32 b).
- Answers the controller's chunk_request / request_type / chunk_index handshake with single-cycle chunk_valid pulses.
- Optionally auto-increments the counter after each completed block, so consecutive blocks use consecutive counters.

Parameters:
- CTR_RESET, 32'h0000_0001, counter value loaded at reset.
- AUTO_INC_STEP, 1, amount added to counter per completed block.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_wr_en  in  1  host write strobe.
- cfg_addr  in  4  0-7 key word 0-7; 8-10 nonce word 0-2; 11 counter; 12-15 invalid.
- cfg_wdata  in  32  host write data.
- cfg_err  out  1  one-cycle pulse: write rejected (locked or bad address).
- auto_inc_en  in  1  enable counter auto-increment.
- core_busy  in  1  controller busy.
- core_done  in  1  controller done pulse.
- chunk_request  in  1  controller requests a word.
- request_type  in  2  0 key, 1 nonce, 2 counter, 3 invalid.
- chunk_index  in  5  word index within the selected field.
- chunk_valid  out  1  one-cycle response pulse.
- chunk_type  out  2  echo of the served request_type.
- chunk  out  32  served word.
- chunk_err  out  1  one-cycle pulse: request could not be served.
- counter_value  out  32  current counter register.
- ctr_wrap  out  1  sticky: counter wrapped past 0xFFFFFFFF.

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - key = 0, nonce = 0, counter = CTR_RESET.
  - chunk_valid, chunk_err, cfg_err, ctr_wrap = 0; chunk_type = 0; chunk = 0.
  - Any pending response is dropped; reset mid-handshake yields no pulse on the following cycle.
- Request acceptance: a request is accepted in cycle N when chunk_request = 1 and chunk_valid = 0 in cycle N.
  - A request sampled while chunk_valid = 1 is ignored. This suppresses the controller's repeated request issued while it waits.
- Valid request: type 0 with index 0-7, type 1 with index 0-2, or type 2 with index 0.
  - Response in cycle N+1: chunk_valid = 1, chunk_type = request_type, chunk = field word[index] (word 0 = bits 31:0).
  - Latency is exactly 1. The pulse lasts exactly 1 cycle.
- Invalid request (type 3 or out-of-range index): chunk_err = 1 in cycle N+1; chunk_valid stays 0; chunk keeps its previous value.
- Outside a valid pulse, chunk and chunk_type hold their last values.
- Lock: while core_busy = 1, every cfg write is rejected (cfg_err pulse next cycle, registers unchanged).
  - Reads via the chunk handshake are always allowed.
- Host writes:
  - A write to addresses 0-11 with core_busy = 0 updates the word on the next edge.
  - A counter write also clears ctr_wrap.
  - Addresses 12-15 give a cfg_err pulse and no update.
- Auto-increment:
  - On core_done = 1 and auto_inc_en = 1: counter <= counter + AUTO_INC_STEP, modulo 2^32.
  - If the addition carries out, ctr_wrap <= 1 (sticky).
- Simultaneous events:
  - Counter write in the same cycle as core_done: the write wins, no increment, ctr_wrap cleared.
  - Key/nonce write in the same cycle as core_done with core_busy = 0: both take effect.
  - A request in the same cycle as a host write serves the pre-write value.
- counter_value is a direct register output.

Test Plan:
- Write key words 0x00010203…0x1C1D1E1F, then request type 0 index 5 held two cycles -> one chunk_valid pulse at N+1 with chunk = 0x14151617 and chunk_type = 0; no second pulse.
- Drive the controller-style sequence (request, wait, request next index) for the whole key, nonce and counter -> exactly 12 valid pulses with correct words in order.
- Request type 3, then type 1 index 3 -> chunk_err pulses at N+1 each, chunk_valid never asserted.
- core_busy = 1 and cfg write counter = 5 -> cfg_err pulse; counter_value unchanged (1 after reset).
- counter = 0xFFFFFFFF, auto_inc_en = 1, core_done pulse -> counter_value = 0, ctr_wrap = 1; then write counter = 7 in the same cycle as another core_done -> counter_value = 7, ctr_wrap = 0.
- Accept a request, assert rst in cycle N+1 -> chunk_valid = 0 at N+1 output, all registers at reset values.
